// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the packet-aware AXI-Stream arbiter.
package axis_arb_pkg;
  localparam int CRED_W = 8;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;
endpackage

// File: rtl/axis_elastic_buf2.sv
// Two-entry elastic AXI-Stream buffer; input ready comes only from registered occupancy.
module axis_elastic_buf2 #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         ready_r;
  logic         wr_s;
  logic         rd_s;
  logic [1:0]   count_next_s;

  assign wr_s         = in_valid & ready_r;
  assign rd_s         = (count_r != 2'd0) & out_ready;
  assign count_next_s = count_r + {1'b0, wr_s} - {1'b0, rd_s};
  assign in_ready     = ready_r;
  assign out_valid    = (count_r != 2'd0);
  assign out_data     = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; ready stays low during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      ready_r  <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (rd_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_next_s;
      ready_r <= (count_next_s != 2'd2);
    end
  end
endmodule

// File: rtl/axis_wrr_pkt_arbiter.sv
// Two-source weighted round-robin AXI-Stream arbiter with packet locking and a registered output stage.
module axis_wrr_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WEIGHT_A = 1,
  parameter int WEIGHT_B = 1
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  input  logic [DATA_W-1:0] s0a_axis_tdata,
  input  logic              s0a_axis_tvalid,
  output logic              s0a_axis_tready,
  input  logic              s0a_axis_tlast,
  input  logic [DATA_W-1:0] s0b_axis_tdata,
  input  logic              s0b_axis_tvalid,
  output logic              s0b_axis_tready,
  input  logic              s0b_axis_tlast,
  output logic [DATA_W-1:0] m0k_axis_tdata,
  output logic              m0k_axis_tvalid,
  input  logic              m0k_axis_tready,
  output logic              m0k_axis_tlast,
  output logic              m0k_axis_tuser,
  output logic              grant_busy
);
  localparam int PW = DATA_W + 2;
  localparam logic [CRED_W-1:0] WGT_A    = CRED_W'(WEIGHT_A);
  localparam logic [CRED_W-1:0] WGT_B    = CRED_W'(WEIGHT_B);
  localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

  arb_state_t        state_r, state_next_s;
  logic              ptr_r, ptr_next_s;
  logic [CRED_W-1:0] credit_r, credit_next_s;
  logic              grant_a_s, grant_b_s, buf_ready_s;
  logic              acc_a_s, acc_b_s, push_s, push_src_s, push_last_s;
  logic [DATA_W-1:0] push_data_s;
  logic [PW-1:0]     out_payload_s;

  function automatic logic [CRED_W-1:0] weight_of(input logic src);
    return (src == SRC_B) ? WGT_B : WGT_A;
  endfunction

  // Grant selection: locked source wins, otherwise the single requester or the pointer owner.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (s0a_axis_tvalid && s0b_axis_tvalid) begin
          grant_a_s = (ptr_r == SRC_A);
          grant_b_s = (ptr_r == SRC_B);
        end else begin
          grant_a_s = s0a_axis_tvalid;
          grant_b_s = s0b_axis_tvalid;
        end
      end
      LOCK_A:  grant_a_s = 1'b1;
      LOCK_B:  grant_b_s = 1'b1;
      default: grant_a_s = 1'b0;
    endcase
  end

  assign s0a_axis_tready = grant_a_s & buf_ready_s;
  assign s0b_axis_tready = grant_b_s & buf_ready_s;
  assign acc_a_s     = s0a_axis_tvalid & s0a_axis_tready;
  assign acc_b_s     = s0b_axis_tvalid & s0b_axis_tready;
  assign push_s      = acc_a_s | acc_b_s;
  assign push_src_s  = acc_b_s ? SRC_B : SRC_A;
  assign push_last_s = acc_b_s ? s0b_axis_tlast : s0a_axis_tlast;
  assign push_data_s = acc_b_s ? s0b_axis_tdata : s0a_axis_tdata;
  assign grant_busy  = (state_r != IDLE);

  // Next state and credit bookkeeping on accepted beats.
  always_comb begin
    state_next_s  = state_r;
    ptr_next_s    = ptr_r;
    credit_next_s = credit_r;
    if (push_s) begin
      if (push_last_s) begin
        state_next_s = IDLE;
        if (push_src_s == ptr_r) begin
          if (credit_r <= CRED_ONE) begin
            ptr_next_s    = ~ptr_r;
            credit_next_s = weight_of(~ptr_r);
          end else begin
            credit_next_s = credit_r - CRED_ONE;
          end
        end else begin
          // Serving the non-owner spends one of its own turns before the pointer settles.
          if (weight_of(push_src_s) <= CRED_ONE) begin
            ptr_next_s    = ~push_src_s;
            credit_next_s = weight_of(~push_src_s);
          end else begin
            ptr_next_s    = push_src_s;
            credit_next_s = weight_of(push_src_s) - CRED_ONE;
          end
        end
      end else begin
        state_next_s = (push_src_s == SRC_B) ? LOCK_B : LOCK_A;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // Arbiter state register.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_r  <= IDLE;
      ptr_r    <= SRC_A;
      credit_r <= WGT_A;
    end else begin
      state_r  <= state_next_s;
      ptr_r    <= ptr_next_s;
      credit_r <= credit_next_s;
    end
  end

  axis_elastic_buf2 #(.W(PW)) u_buf (
    .clk       (axis_aclk),
    .rst_n     (axis_aresetn),
    .in_data   ({push_src_s, push_last_s, push_data_s}),
    .in_valid  (push_s),
    .in_ready  (buf_ready_s),
    .out_data  (out_payload_s),
    .out_valid (m0k_axis_tvalid),
    .out_ready (m0k_axis_tready)
  );

  assign m0k_axis_tuser = out_payload_s[PW-1];
  assign m0k_axis_tlast = out_payload_s[PW-2];
  assign m0k_axis_tdata = out_payload_s[DATA_W-1:0];
endmodule

// File: tb/tb_axis_wrr_pkt_arbiter.sv
// Randomized bench for axis_wrr_pkt_arbiter against a transaction-level arbitration model.
module tb_axis_wrr_pkt_arbiter;
  localparam int W_A = 3;
  localparam int W_B = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_data, b_data, m_data;
  logic        a_valid, a_last, b_valid, b_last, m_ready;
  logic        a_ready, b_ready, m_valid, m_last, m_user, busy;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [33:0] q_exp[$];
  int          lock_src;
  int          ptr;
  int          credit;
  int          weight[2];
  int          pkt_len[2], beat[2], pkt_id[2];
  logic        vld[2];
  int          p_valid[2];
  int          p_ready;
  logic        pend_pop;
  int          pend_acc;

  axis_wrr_pkt_arbiter #(.DATA_W(32), .WEIGHT_A(W_A), .WEIGHT_B(W_B)) u_dut (
    .axis_aclk       (clk),
    .axis_aresetn    (rst_n),
    .s0a_axis_tdata  (a_data),
    .s0a_axis_tvalid (a_valid),
    .s0a_axis_tready (a_ready),
    .s0a_axis_tlast  (a_last),
    .s0b_axis_tdata  (b_data),
    .s0b_axis_tvalid (b_valid),
    .s0b_axis_tready (b_ready),
    .s0b_axis_tlast  (b_last),
    .m0k_axis_tdata  (m_data),
    .m0k_axis_tvalid (m_valid),
    .m0k_axis_tready (m_ready),
    .m0k_axis_tlast  (m_last),
    .m0k_axis_tuser  (m_user),
    .grant_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input int s);
    logic [7:0]  sid;
    logic [15:0] pid;
    logic [7:0]  bid;
    sid = 8'(s + 1);
    pid = 16'(pkt_id[s]);
    bid = 8'(beat[s]);
    return {sid, pid, bid};
  endfunction

  function automatic logic is_last(input int s);
    return (beat[s] == pkt_len[s] - 1);
  endfunction

  task automatic new_packet(input int s);
    pkt_id[s]++;
    beat[s]    = 0;
    pkt_len[s] = $urandom_range(4, 1);
  endtask

  task automatic model_reset();
    q_exp.delete();
    lock_src = -1;
    ptr      = 0;
    credit   = weight[0];
    pend_pop = 1'b0;
    pend_acc = -1;
    for (int s = 0; s < 2; s++) begin
      vld[s] = 1'b0;
      new_packet(s);
    end
    a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
    a_data  = 32'd0; b_data = 32'd0; m_ready = 1'b0;
  endtask

  // Packet-level weighted round-robin bookkeeping, straight from the rules.
  task automatic packet_done(input int s);
    if (s == ptr) begin
      credit = credit - 1;
      if (credit <= 0) begin
        ptr    = 1 - ptr;
        credit = weight[ptr];
      end
    end else begin
      ptr    = s;
      credit = weight[s] - 1;
      if (credit == 0) begin
        ptr    = 1 - s;
        credit = weight[ptr];
      end
    end
  endtask

  task automatic step();
    int   g;
    logic room, exp_ra, exp_rb;
    @(posedge clk);
    if (pend_pop) void'(q_exp.pop_front());
    if (pend_acc >= 0) begin
      q_exp.push_back({pend_acc[0], is_last(pend_acc), beat_data(pend_acc)});
      vld[pend_acc] = 1'b0;
      if (is_last(pend_acc)) begin
        lock_src = -1;
        packet_done(pend_acc);
        new_packet(pend_acc);
      end else begin
        lock_src = pend_acc;
        beat[pend_acc]++;
      end
    end
    #1;
    for (int s = 0; s < 2; s++)
      if (!vld[s]) vld[s] = ($urandom_range(99) < p_valid[s]);
    a_valid = vld[0]; a_data = beat_data(0); a_last = is_last(0);
    b_valid = vld[1]; b_data = beat_data(1); b_last = is_last(1);
    m_ready = ($urandom_range(99) < p_ready);
    @(negedge clk);
    if (lock_src >= 0)         g = lock_src;
    else if (vld[0] && vld[1]) g = ptr;
    else if (vld[0])           g = 0;
    else if (vld[1])           g = 1;
    else                       g = -1;
    room   = (q_exp.size() < 2);
    exp_ra = (g == 0) && room;
    exp_rb = (g == 1) && room;
    check_val("a_ready", a_ready, exp_ra);
    check_val("b_ready", b_ready, exp_rb);
    check_val("grant_busy", busy, lock_src >= 0);
    check_val("m_valid", m_valid, q_exp.size() > 0);
    if (q_exp.size() > 0) check_val("m_beat", {m_user, m_last, m_data}, q_exp[0]);
    pend_pop = (q_exp.size() > 0) && m_ready;
    if (exp_ra && vld[0])      pend_acc = 0;
    else if (exp_rb && vld[1]) pend_acc = 1;
    else                       pend_acc = -1;
  endtask

  task automatic phase(input int n, input int pa, input int pb, input int pr);
    p_valid[0] = pa; p_valid[1] = pb; p_ready = pr;
    repeat (n) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_m_valid"}, m_valid, 1'b0);
    check_val({tag, "_a_ready"}, a_ready, 1'b0);
    check_val({tag, "_b_ready"}, b_ready, 1'b0);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_m_payload"}, {m_user, m_last, m_data}, 34'd0);
  endtask

  initial begin
    int budget;
    weight[0] = W_A; weight[1] = W_B;
    pkt_id[0] = 0; pkt_id[1] = 256;
    rst_n = 1'b0;
    model_reset();
    a_valid = 1'b1; b_valid = 1'b1;
    #3;
    check_reset_outputs("rst_init");
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk); #2; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    phase(60, 100, 0, 100);
    phase(80, 100, 100, 100);
    phase(400, 60, 60, 70);
    phase(15, 100, 100, 0);
    phase(40, 100, 100, 100);

    // Reset while a source is mid-packet.
    p_valid[0] = 100; p_valid[1] = 100; p_ready = 100;
    budget = 0;
    while (!(lock_src >= 0 && q_exp.size() > 0) && budget < 200) begin
      step();
      budget++;
    end
    check_val("lock_reached", (lock_src >= 0 && q_exp.size() > 0), 1'b1);
    #2; rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk); #2; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    phase(300, 70, 70, 60);
    phase(60, 100, 100, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_wrr_pkt_arbiter.md
Name: axis_wrr_pkt_arbiter

Overview:
- Two-input, packet-aware AXI-Stream arbiter feeding one master port, which is the port the downstream datapath consumes.
- Grants are weighted round-robin at packet granularity. Once a packet's first beat is accepted, the grant is locked to that source until its tlast beat is accepted.
- The output is registered through a 2-entry elastic buffer: full throughput, no combinational path from m0k_axis_tready to the s*_tready outputs.
- m0k_axis_tuser tags every beat with its source.

Parameters:
- DATA_W, 32, tdata width of all ports.
- WEIGHT_A, 1, packets source A may send per turn when B is contending; legal range 1..255.
- WEIGHT_B, 1, packets source B may send per turn when A is contending; legal range 1..255.

Ports:
- axis_aclk  in  1  clock.
- axis_aresetn  in  1  reset, asynchronous, active-low.
- s0a_axis_tdata  in  DATA_W  source A data.
- s0a_axis_tvalid  in  1  source A valid.
- s0a_axis_tready  out  1  source A ready.
- s0a_axis_tlast  in  1  source A end of packet.
- s0b_axis_tdata / tvalid / tready / tlast: same widths and directions, source B.
- m0k_axis_tdata  out  DATA_W  merged data.
- m0k_axis_tvalid  out  1  merged valid.
- m0k_axis_tready  in  1  downstream ready.
- m0k_axis_tlast  out  1  merged end of packet.
- m0k_axis_tuser  out  1  source id of the beat: 0 = A, 1 = B.
- grant_busy  out  1  high while in LOCK_A or LOCK_B.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, ptr = A, credit = WEIGHT_A, buffer empty.
  - m0k_axis_tvalid, s0a_axis_tready, s0b_axis_tready, grant_busy all 0.
  - tdata/tlast/tuser outputs 0.
- Buffer (sub-module):
  - 2-entry elastic buffer; buf_ready = not full.
  - Latency 1 cycle from input accept to m0k_axis_tvalid.
  - Sustains 1 beat/clk under continuous tready.
- Accept: a beat is accepted when s*_tvalid & s*_tready.
- Ready rule: s*_tready = grant(source) & buf_ready. Only one s*_tready may be high in any cycle.
- States: IDLE, LOCK_A, LOCK_B.
- IDLE grant (combinational, same cycle, no bubble):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant ptr.
  - Neither valid -> no grant; all s*_tready = 0.
- IDLE transitions:
  - Accept without tlast -> LOCK_x of the granted source.
  - Accept with tlast (single-beat packet) -> stay IDLE; packet complete.
- LOCK_x:
  - grant = x only; the other source's tready is held 0 regardless of its tvalid.
  - Accepted beat with tlast -> IDLE; packet complete.
  - tvalid low mid-packet: stay locked, no timeout.
- Packet complete from source x:
  - If x == ptr: credit decrements. If it reaches 0 -> ptr flips, credit reloads with the new owner's WEIGHT.
  - If x != ptr (owner idle, other side served): ptr moves to x, credit = WEIGHT_x - 1. If that is 0 -> ptr flips back, credit reloads.
- Credit width: 8 bits, never wraps below 0.
- Ordering: beats leave in accept order; no reordering, and no interleaving within a packet.
- Buffer full: both s*_tready = 0; state and credit hold.
- tuser/tlast/tdata are stored alongside each beat in the buffer.
- Reset mid-packet: everything returns to reset values immediately. Buffered beats are dropped; a partially sent packet is not completed.
- grant_busy = (state != IDLE).

Decomposition:
- Shared package axis_arb_pkg:
  - state encoding constants IDLE=2'd0, LOCK_A=2'd1, LOCK_B=2'd2
  - SRC_A=1'b0, SRC_B=1'b1
  - CRED_W=8
- One sub-module: axis_elastic_buf2, a 2-entry AXI-Stream buffer parameterised by payload width. Payload = {tuser, tlast, tdata}. Reused for any future port.

Test Plan:
- Single source, continuous: A sends 3 packets of 4 beats (data 0x10..0x1B), tready=1 -> 12 consecutive output beats, tuser=0, tlast on beats 4/8/12, first output 1 cycle after first accept.
- Contention, equal weights: A and B both hold 2-beat packets continuously, WEIGHT_A=WEIGHT_B=1 -> output packet source order A,B,A,B; no interleaving within a packet.
- Weighted: WEIGHT_A=3, WEIGHT_B=1, both always valid with 1-beat packets -> tuser sequence 0,0,0,1,0,0,0,1; throughput 1 beat/clk.
- Lock under contention: A starts a 5-beat packet and drops tvalid for 3 cycles after beat 2 while B is valid -> s0b_axis_tready stays 0 throughout, grant_busy=1, B granted only after A's tlast.
- Backpressure: m0k_axis_tready=0 for 10 cycles with A streaming -> exactly 2 beats accepted, both s*_tready=0 afterward, no data loss or duplication after release.
- Async reset mid-packet: assert axis_aresetn=0 during beat 3 of 6 -> m0k_axis_tvalid and all tready drop to 0 without a clock edge; after release state=IDLE, ptr=A, first new packet passes intact.
